// File: rtl/io_map_pkg.sv
// Register map for the io_led_bank peripheral.
// Shared offset constants and bank operation encoding.
package io_map_pkg;

  localparam logic [4:0] OFF_DATA  = 5'h00;
  localparam logic [4:0] OFF_SET   = 5'h04;
  localparam logic [4:0] OFF_CLR   = 5'h08;
  localparam logic [4:0] OFF_TOG   = 5'h0C;
  localparam logic [4:0] OFF_DUTY  = 5'h10;
  localparam logic [4:0] OFF_BCAST = 5'h1F;

  typedef enum logic [1:0] {
    OP_DATA = 2'd0,
    OP_SET  = 2'd1,
    OP_CLR  = 2'd2,
    OP_TOG  = 2'd3
  } bank_op_e;

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with duty compare.
// All-ones duty forces the output fully on.
module pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_on
);

  logic [PWM_W-1:0] cnt;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) cnt <= '0;
    else          cnt <= cnt + 1'b1;
  end

  assign pwm_on = (&duty) | (cnt < duty);

endmodule

// File: rtl/io_led_bank.sv
// Memory-mapped LED/GPIO output banks with set/clr/toggle,
// broadcast alias, global PWM brightness and registered read-back.
module io_led_bank #(
  parameter int                NBANKS    = 4,
  parameter int                BANK_W    = 8,
  parameter logic [31:0]       BASE_ADDR = 32'h0000_03E0,
  parameter int                PWM_W     = 8,
  parameter logic [BANK_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  input  logic [31:0]              io_addr,
  input  logic [31:0]              io_wdata,
  input  logic                     io_wr,
  input  logic                     io_rd,
  output logic [31:0]              io_rdata,
  output logic                     io_rdy,
  output logic [NBANKS*BANK_W-1:0] bank_out
);

  import io_map_pkg::*;

  logic [BANK_W-1:0] data  [NBANKS];
  logic [BANK_W-1:0] dnext [NBANKS];
  logic [PWM_W-1:0]  duty;
  logic              pwm_on;
  logic              hit;
  logic              is_bank;
  logic [4:0]        off;
  logic [1:0]        idx;
  bank_op_e          op;
  logic [BANK_W-1:0] wv;
  logic [31:0]       rd_val;

  assign hit     = io_addr[31:5] == BASE_ADDR[31:5];
  assign off     = io_addr[4:0];
  assign idx     = off[1:0];
  assign op      = bank_op_e'(off[3:2]);
  assign is_bank = hit && (off < OFF_DUTY);
  assign wv      = io_wdata[BANK_W-1:0];

  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      dnext[b] = data[b];
      if (io_wr && hit && off == OFF_BCAST) begin
        dnext[b] = wv;
      end else if (io_wr && is_bank && idx == 2'(b)) begin
        case (op)
          OP_DATA: dnext[b] = wv;
          OP_SET:  dnext[b] = data[b] | wv;
          OP_CLR:  dnext[b] = data[b] & ~wv;
          OP_TOG:  dnext[b] = data[b] ^ wv;
          default: dnext[b] = data[b];
        endcase
      end
    end
  end

  // Read value uses pre-write state so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    if (hit && off == OFF_DUTY) begin
      rd_val[PWM_W-1:0] = duty;
    end else if (is_bank) begin
      for (int b = 0; b < NBANKS; b++)
        if (idx == 2'(b)) rd_val[BANK_W-1:0] = data[b];
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NBANKS; b++) data[b] <= RESET_VAL;
      duty <= '1;
    end else begin
      for (int b = 0; b < NBANKS; b++) data[b] <= dnext[b];
      if (io_wr && hit && off == OFF_DUTY)
        duty <= io_wdata[PWM_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      io_rdy   <= 1'b0;
      io_rdata <= '0;
    end else begin
      io_rdy <= io_rd;
      if (io_rd) io_rdata <= rd_val;
    end
  end

  pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clk     (clk),
    .Reset_n (Reset_n),
    .duty    (duty),
    .pwm_on  (pwm_on)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bank_out <= {NBANKS{RESET_VAL}};
    end else begin
      for (int b = 0; b < NBANKS; b++)
        bank_out[b*BANK_W +: BANK_W] <= data[b] & {BANK_W{pwm_on}};
    end
  end

endmodule

// File: tb/tb_io_led_bank.sv
// Bench for io_led_bank: directed scenarios plus random traffic
// checked against an address-level register model.
module tb_io_led_bank;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic        io_wr = 1'b0;
  logic        io_rd = 1'b0;
  logic [31:0] io_rdata;
  logic        io_rdy;
  logic [31:0] bank_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mdata [4];
  logic [7:0] mduty;

  io_led_bank dut (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_rdata (io_rdata),
    .io_rdy   (io_rdy),
    .bank_out (bank_out)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mdata[i] = 8'h00;
    mduty = 8'hFF;
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic [31:0] w);
    int o;
    if (a[31:5] != 27'h1F) return;
    o = int'(a[4:0]);
    if (o == 31) begin
      for (int i = 0; i < 4; i++) mdata[i] = w[7:0];
    end else if (o == 16) begin
      mduty = w[7:0];
    end else if (o < 16) begin
      case (o / 4)
        0: mdata[o % 4] = w[7:0];
        1: mdata[o % 4] = mdata[o % 4] | w[7:0];
        2: mdata[o % 4] = mdata[o % 4] & ~w[7:0];
        default: mdata[o % 4] = mdata[o % 4] ^ w[7:0];
      endcase
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int o;
    if (a[31:5] != 27'h1F) return 32'h0;
    o = int'(a[4:0]);
    if (o < 16) return {24'h0, mdata[o % 4]};
    if (o == 16) return {24'h0, mduty};
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_pins();
    return {mdata[3], mdata[2], mdata[1], mdata[0]};
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    io_addr = a; io_wdata = w; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
    model_write(a, w);
  endtask

  task automatic do_read(input logic [31:0] a,
                         output logic rdy, output logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_rd = 1'b1;
    @(negedge clk);
    io_rd = 1'b0;
    rdy = io_rdy; d = io_rdata;
  endtask

  task automatic test_reset();
    logic r; logic [31:0] d;
    n_cmp++;
    if (bank_out !== 32'h0 || io_rdy !== 1'b0 || io_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: out=%h rdy=%b rdata=%h want 0/0/0",
               bank_out, io_rdy, io_rdata);
    end
    @(negedge clk); Reset_n = 1'b1; model_reset();
    do_write(32'h3E0, 32'h55);
    @(negedge clk);
    io_addr = 32'h3E0; io_rd = 1'b1;
    @(posedge clk); #2;
    Reset_n = 1'b0; io_rd = 1'b0;
    #1;
    n_cmp++;
    if (bank_out !== 32'h0 || io_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: out=%h rdy=%b want 0/0", bank_out, io_rdy);
    end
    @(negedge clk); Reset_n = 1'b1; model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (io_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_cancel: rdy=%b want 0", io_rdy);
      end
    end
    do_read(32'h3F0, r, d);
    n_cmp++;
    if (r !== 1'b1 || d !== 32'hFF) begin
      n_err++;
      $display("FAIL reset_duty: rdy=%b data=%h want 1/000000ff", r, d);
    end
  endtask

  task automatic test_write();
    do_write(32'h3E0, 32'hA5);
    n_cmp++;
    if (bank_out !== 32'h0) begin
      n_err++;
      $display("FAIL write_latency: out=%h want 00000000", bank_out);
    end
    @(negedge clk);
    n_cmp++;
    if (bank_out !== 32'h0000_00A5) begin
      n_err++;
      $display("FAIL write_data: out=%h want 000000a5", bank_out);
    end
    do_write(32'h3FF, 32'h3C);
    @(negedge clk);
    n_cmp++;
    if (bank_out !== 32'h3C3C_3C3C) begin
      n_err++;
      $display("FAIL write_bcast: out=%h want 3c3c3c3c", bank_out);
    end
  endtask

  task automatic test_set_clr_tog();
    logic [7:0] exp [3];
    logic [31:0] addr [3];
    exp[0] = 8'h0F; exp[1] = 8'h0C; exp[2] = 8'hF3;
    addr[0] = 32'h3E5; addr[1] = 32'h3E9; addr[2] = 32'h3ED;
    do_write(32'h3E1, 32'h00);
    for (int i = 0; i < 3; i++) begin
      do_write(addr[i], i == 0 ? 32'h0F : (i == 1 ? 32'h03 : 32'hFF));
      @(negedge clk);
      n_cmp++;
      if (bank_out[15:8] !== exp[i] || bank_out !== model_pins()) begin
        n_err++;
        $display("FAIL set_clr_tog_%0d: out=%h want bank1 %h", i,
                 bank_out, exp[i]);
      end
    end
  endtask

  task automatic test_read();
    logic r; logic [31:0] d;
    do_read(32'h3E1, r, d);
    n_cmp++;
    if (r !== 1'b1 || d !== 32'h0000_00F3) begin
      n_err++;
      $display("FAIL read_bank1: rdy=%b data=%h want 1/000000f3", r, d);
    end
    do_read(32'h3E4, r, d);
    n_cmp++;
    if (r !== 1'b1 || d !== {24'h0, mdata[0]}) begin
      n_err++;
      $display("FAIL read_set_alias: rdy=%b data=%h want 1/%h", r, d,
               {24'h0, mdata[0]});
    end
    do_read(32'h3DF, r, d);
    n_cmp++;
    if (r !== 1'b1 || d !== 32'h0) begin
      n_err++;
      $display("FAIL read_miss: rdy=%b data=%h want 1/0", r, d);
    end
    do_read(32'h3FF, r, d);
    n_cmp++;
    if (r !== 1'b1 || d !== 32'h0) begin
      n_err++;
      $display("FAIL read_bcast: rdy=%b data=%h want 1/0", r, d);
    end
    @(negedge clk);
    n_cmp++;
    if (io_rdy !== 1'b0 || io_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL read_idle: rdy=%b data=%h want 0/hold 0", io_rdy,
               io_rdata);
    end
  endtask

  task automatic test_pwm();
    logic [7:0] duties [3];
    int want [3];
    int hi;
    duties[0] = 8'h40; duties[1] = 8'h00; duties[2] = 8'hFF;
    want[0] = 64; want[1] = 0; want[2] = 256;
    do_write(32'h3FF, 32'hFF);
    for (int k = 0; k < 3; k++) begin
      do_write(32'h3F0, {24'h0, duties[k]});
      repeat (3) @(negedge clk);
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (bank_out === 32'hFFFF_FFFF) hi++;
        else if (bank_out !== 32'h0) hi = -1000;
      end
      n_cmp++;
      if (hi != want[k]) begin
        n_err++;
        $display("FAIL pwm_duty_%h: high=%0d want %0d", duties[k], hi,
                 want[k]);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic r; logic [31:0] d;
    do_write(32'h3E2, 32'h11);
    @(negedge clk);
    io_addr = 32'h3E2; io_wdata = 32'h22; io_wr = 1'b1; io_rd = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; io_rd = 1'b0;
    model_write(32'h3E2, 32'h22);
    n_cmp++;
    if (io_rdy !== 1'b1 || io_rdata !== 32'h11) begin
      n_err++;
      $display("FAIL same_cycle_old: rdy=%b data=%h want 1/11", io_rdy,
               io_rdata);
    end
    do_read(32'h3E2, r, d);
    n_cmp++;
    if (r !== 1'b1 || d !== 32'h22) begin
      n_err++;
      $display("FAIL same_cycle_new: rdy=%b data=%h want 1/22", r, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] last;
    @(negedge clk);
    io_addr = 32'h3E0; io_rd = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (io_rdy !== 1'b1 || io_rdata !== model_read(32'h3E0)) begin
      n_err++;
      $display("FAIL b2b_first: rdy=%b data=%h want 1/%h", io_rdy,
               io_rdata, model_read(32'h3E0));
    end
    io_addr = 32'h3E1;
    @(negedge clk);
    io_rd = 1'b0;
    n_cmp++;
    if (io_rdy !== 1'b1 || io_rdata !== model_read(32'h3E1)) begin
      n_err++;
      $display("FAIL b2b_second: rdy=%b data=%h want 1/%h", io_rdy,
               io_rdata, model_read(32'h3E1));
    end
    last = model_read(32'h3E1);
    @(negedge clk);
    n_cmp++;
    if (io_rdy !== 1'b0 || io_rdata !== last) begin
      n_err++;
      $display("FAIL b2b_end: rdy=%b data=%h want 0/%h", io_rdy,
               io_rdata, last);
    end
  endtask

  task automatic test_random();
    logic r; logic [31:0] d, a, w;
    do_write(32'h3F0, 32'hFF);
    for (int i = 0; i < 60; i++) begin
      a = 32'h3E0 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = 32'h3C0 + 32'($urandom_range(0, 95));
      if (a == 32'h3F0) a = 32'h3F1;
      w = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, w);
        @(negedge clk);
        n_cmp++;
        if (bank_out !== model_pins()) begin
          n_err++;
          $display("FAIL rand_wr_%0d: addr=%h out=%h want %h", i, a,
                   bank_out, model_pins());
        end
      end else begin
        do_read(a, r, d);
        n_cmp++;
        if (r !== 1'b1 || d !== model_read(a)) begin
          n_err++;
          $display("FAIL rand_rd_%0d: addr=%h rdy=%b data=%h want 1/%h",
                   i, a, r, d, model_read(a));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_write();
    test_set_clr_tog();
    test_read();
    test_pwm();
    test_same_cycle();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
